div_seq_param: RTL and testbench

- Parametrised sequential restoring divider; next generation of the team's 4-bit go/done divider.
- Computes q = x / y and r = x mod y for WIDTH-bit operands, producing one quotient bit per clock.
- Internally a control FSM plus a datapath with shift/subtract registers; exports the current state on CS for board-level debug.
- Adds a divide-by-zero error path, back-to-back restart from the DONE state, and optional signed mode.

---
 rtl/div_seq_param.sv | 134 +++++++++++++
 tb/tb_div_seq_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_param.sv
// div_seq_param: sequential restoring divider, one quotient bit per clock, divide-by-zero trap.
// Define SIGNED_DIV_EN for two's-complement operands with a FIX state for sign correction.
module div_seq_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic [2:0]       CS,
   output logic             done,
   output logic             error
);
   typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, ITER = 3'd2, FIX = 3'd3, DONE = 3'd4, ERR = 3'd5} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] rr_q, rr_d, xx_q, xx_d, yy_q, yy_d, q_q, q_d, r_q, r_d, r_nx, x_nx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d, error_q, error_d, ge;
   logic [WIDTH:0]   r_sh;
`ifdef SIGNED_DIV_EN
   logic             sgn_q_q, sgn_q_d, sgn_r_q, sgn_r_d;
`endif
   // Shifted partial remainder keeps its carry-out bit so divisors above 2^(WIDTH-1) stay exact.
   always_comb begin
      r_sh = {rr_q, xx_q[WIDTH-1]};
      ge   = r_sh >= {1'b0, yy_q};
      r_nx = ge ? WIDTH'(r_sh - {1'b0, yy_q}) : r_sh[WIDTH-1:0];
      x_nx = {xx_q[WIDTH-2:0], ge};
   end
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      xx_d    = xx_q;
      yy_d    = yy_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      done_d  = done_q;
      error_d = error_q;
`ifdef SIGNED_DIV_EN
      sgn_q_d = sgn_q_q;
      sgn_r_d = sgn_r_q;
`endif
      case (state_q)
         IDLE, DONE, ERR: if (go) begin
            state_d = LOAD;
            xx_d    = x;
            yy_d    = y;
            rr_d    = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
         end
         LOAD: if (yy_q == '0) begin
            state_d = ERR;
            error_d = 1'b1;
            q_d     = '1;
            r_d     = xx_q;
         end else begin
            state_d = ITER;
            cnt_d   = CNT_W'(WIDTH);
`ifdef SIGNED_DIV_EN
            xx_d    = xx_q[WIDTH-1] ? -xx_q : xx_q;
            yy_d    = yy_q[WIDTH-1] ? -yy_q : yy_q;
            sgn_q_d = xx_q[WIDTH-1] ^ yy_q[WIDTH-1];
            sgn_r_d = xx_q[WIDTH-1];
`endif
         end
         ITER: begin
            rr_d  = r_nx;
            xx_d  = x_nx;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
`ifdef SIGNED_DIV_EN
               state_d = FIX;
`else
               state_d = DONE;
               done_d  = 1'b1;
               q_d     = x_nx;
               r_d     = r_nx;
`endif
            end
         end
`ifdef SIGNED_DIV_EN
         FIX: begin
            state_d = DONE;
            done_d  = 1'b1;
            q_d     = sgn_q_q ? -xx_q : xx_q;
            r_d     = sgn_r_q ? -rr_q : rr_q;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         xx_q    <= '0;
         yy_q    <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
`ifdef SIGNED_DIV_EN
         sgn_q_q <= 1'b0;
         sgn_r_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         xx_q    <= xx_d;
         yy_q    <= yy_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         done_q  <= done_d;
         error_q <= error_d;
`ifdef SIGNED_DIV_EN
         sgn_q_q <= sgn_q_d;
         sgn_r_q <= sgn_r_d;
`endif
      end
   end
   assign q     = q_q;
   assign r     = r_q;
   assign CS    = state_q;
   assign done  = done_q;
   assign error = error_q;
endmodule

// File: tb/tb_div_seq_param.sv
// tb_div_seq_param: randomized self-checking bench for div_seq_param against an arithmetic model.
module tb_div_seq_param;
   localparam int W = 8;
`ifdef SIGNED_DIV_EN
   localparam int LAT = W + 2;
`else
   localparam int LAT = W + 1;
`endif
   logic         clk = 1'b0, rst = 1'b1, go = 1'b0;
   logic [W-1:0] x = '0, y = '0, q, r;
   logic [2:0]   cs;
   logic         done, error;
   int           vec = 0, miss = 0;

   div_seq_param #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .go(go), .x(x), .y(y),
      .q(q), .r(r), .CS(cs), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Expected {q, r}: plain integer division (truncating), or the error pattern for y == 0.
   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb;
`ifdef SIGNED_DIV_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      if (sb == 0) return {{W{1'b1}}, a};
      return {W'(sa / sb), W'(sa % sb)};
   endfunction

   // Pulse go for one edge with the given operands, then wait n more falling edges.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
      @(negedge clk);
      x  = a;
      y  = b;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      vec++;
      if ({q, r, done, error, cs} !== '0) begin
         miss++;
         $display("FAIL reset q=%h r=%h done=%b error=%b cs=%0d, want all zero", q, r, done, error, cs);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [2*W-1:0] e;
      e = model(8'd200, 8'd7);
      launch(8'd200, 8'd7, LAT - 1);
      vec++;
      if (done !== 1'b0) begin
         miss++;
         $display("FAIL basic_early done=%b want 0", done);
      end
      @(negedge clk);
      vec++;
      if ({q, r, done, error, cs} !== {e, 1'b1, 1'b0, 3'd4}) begin
         miss++;
         $display("FAIL basic q=%0d r=%0d done=%b err=%b cs=%0d want q=%0d r=%0d done=1 err=0 cs=4",
                  q, r, done, error, cs, e[2*W-1:W], e[W-1:0]);
      end
      x = 8'd3;
      y = 8'd5;
      repeat (3) @(negedge clk);
      vec++;
      if ({q, r, done} !== {e, 1'b1}) begin
         miss++;
         $display("FAIL basic_hold q=%0d r=%0d done=%b want q=%0d r=%0d done=1", q, r, done, e[2*W-1:W], e[W-1:0]);
      end
   endtask

   task automatic test_div_zero();
      launch(8'd13, 8'd0, 1);
      vec++;
      if ({cs, error, q, r, done} !== {3'd5, 1'b1, 8'hFF, 8'd13, 1'b0}) begin
         miss++;
         $display("FAIL div_zero cs=%0d err=%b q=%h r=%0d done=%b want cs=5 err=1 q=ff r=13 done=0",
                  cs, error, q, r, done);
      end
      repeat (3) @(negedge clk);
      vec++;
      if ({cs, error} !== {3'd5, 1'b1}) begin
         miss++;
         $display("FAIL div_zero_stay cs=%0d err=%b want cs=5 err=1", cs, error);
      end
      launch(8'd9, 8'd3, LAT);
      vec++;
      if ({q, r, done, error} !== {8'd3, 8'd0, 1'b1, 1'b0}) begin
         miss++;
         $display("FAIL err_recover q=%0d r=%0d done=%b err=%b want q=3 r=0 done=1 err=0", q, r, done, error);
      end
   endtask

   task automatic test_boundaries();
      logic [W-1:0]   bx[3] = '{8'd5, 8'd255, 8'd0};
      logic [W-1:0]   by[3] = '{8'd9, 8'd1, 8'd4};
      logic [2*W-1:0] e;
      for (int i = 0; i < 3; i++) begin
         e = model(bx[i], by[i]);
         launch(bx[i], by[i], LAT);
         vec++;
         if ({q, r, done} !== {e, 1'b1}) begin
            miss++;
            $display("FAIL boundary x=%0d y=%0d q=%0d r=%0d done=%b want q=%0d r=%0d done=1",
                     bx[i], by[i], q, r, done, e[2*W-1:W], e[W-1:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      x  = 8'd100;
      y  = 8'd3;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      vec++;
      if ({q, r, done, error, cs} !== '0) begin
         miss++;
         $display("FAIL reset_mid q=%h r=%h done=%b err=%b cs=%0d want all zero", q, r, done, error, cs);
      end
      @(negedge clk);
      rst = 1'b0;
      launch(8'd100, 8'd3, LAT);
      vec++;
      if ({q, r, done} !== {8'd33, 8'd1, 1'b1}) begin
         miss++;
         $display("FAIL after_reset q=%0d r=%0d done=%b want q=33 r=1 done=1", q, r, done);
      end
   endtask

   task automatic test_random();
      logic [W-1:0]   a, b;
      logic [2*W-1:0] e;
      for (int i = 0; i < 40; i++) begin
         a = W'($urandom);
         b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
         e = model(a, b);
         launch(a, b, (b == '0) ? 1 : LAT);
         vec++;
         if ({q, r, done, error} !== {e, b != '0, b == '0}) begin
            miss++;
            $display("FAIL random x=%h y=%h q=%h r=%h done=%b err=%b want q=%h r=%h done=%b err=%b",
                     a, b, q, r, done, error, e[2*W-1:W], e[W-1:0], b != '0, b == '0);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]   px[5], py[5];
      logic [2*W-1:0] e;
      for (int i = 0; i < 5; i++) begin
         px[i] = W'($urandom);
         py[i] = W'($urandom_range(1, 2**W - 1));
      end
      @(negedge clk);
      x  = px[0];
      y  = py[0];
      go = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vec++;
         if ({cs, done} !== {3'd1, 1'b0}) begin
            miss++;
            $display("FAIL b2b_restart op=%0d cs=%0d done=%b want cs=1 done=0", i, cs, done);
         end
         x = px[i+1];
         y = py[i+1];
         repeat (LAT) @(negedge clk);
         e = model(px[i], py[i]);
         vec++;
         if ({q, r, done, cs} !== {e, 1'b1, 3'd4}) begin
            miss++;
            $display("FAIL b2b op=%0d q=%h r=%h done=%b cs=%0d want q=%h r=%h done=1 cs=4",
                     i, q, r, done, cs, e[2*W-1:W], e[W-1:0]);
         end
      end
      @(negedge clk);
      go = 1'b0;
      repeat (LAT + 1) @(negedge clk);
   endtask

   task automatic test_go_ignored();
      logic [2*W-1:0] e;
      e = model(8'd100, 8'd3);
      @(negedge clk);
      x  = 8'd100;
      y  = 8'd3;
      go = 1'b1;
      @(negedge clk);
      for (int k = 0; k < LAT - 1; k++) begin
         go = k[0] ? 1'b0 : 1'b1;
         x  = W'($urandom);
         y  = W'($urandom);
         @(negedge clk);
      end
      go = 1'b0;
      @(negedge clk);
      vec++;
      if ({q, r, done} !== {e, 1'b1}) begin
         miss++;
         $display("FAIL go_ignored q=%0d r=%0d done=%b want q=%0d r=%0d done=1", q, r, done, e[2*W-1:W], e[W-1:0]);
      end
   endtask

`ifdef SIGNED_DIV_EN
   task automatic test_signed();
      launch(8'hF9, 8'd2, LAT);
      vec++;
      if ({q, r, done} !== {8'hFD, 8'hFF, 1'b1}) begin
         miss++;
         $display("FAIL signed_neg q=%h r=%h done=%b want q=fd r=ff done=1", q, r, done);
      end
      launch(8'h80, 8'hFF, LAT);
      vec++;
      if ({q, r, done, error} !== {8'h80, 8'h00, 1'b1, 1'b0}) begin
         miss++;
         $display("FAIL signed_min q=%h r=%h done=%b err=%b want q=80 r=00 done=1 err=0", q, r, done, error);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_boundaries();
      test_reset_mid();
      test_random();
      test_back_to_back();
      test_go_ignored();
`ifdef SIGNED_DIV_EN
      test_signed();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
